instr_fetch: RTL and testbench

- Fetch sequencer directly downstream of the instruction pointer.
- Takes the current IP, issues a read to instruction memory and holds the fetched word for the decoder under a valid/ready handshake.
- Returns the IP adjustment (sequential +1 or taken-branch offset) and a single-cycle update strobe, which drives the pointer's update clock.

---
 rtl/instr_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_instr_fetch.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch sequencer that sits between the instruction pointer and
// the decoder. It reads the word at the current IP from instruction memory,
// holds it for the decoder under a valid/ready handshake, and then returns
// the IP adjustment along with a one-cycle update strobe.
//
// Optional build macro FETCH_TIMEOUT_EN adds a memory-ack watchdog. A fetch
// that sees no ack for TIMEOUT_CYCLES request cycles parks the block in FAULT
// with a sticky fault flag. Only reset leaves FAULT. Without the macro a
// request waits indefinitely and fault_o is constant 0.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | stopped; waits for run_i
//   S_REQ     | read request outstanding; address held stable
//   S_HOLD    | instruction presented to the decoder; waits for handshake
//   S_ADVANCE | ip_update strobe high; refetch from the new IP if running
//   S_FAULT   | memory never acknowledged (FETCH_TIMEOUT_EN only)
module instr_fetch #(
  parameter int WORD_WIDTH     = 16,
  parameter int INSTR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   run_i,
  input  logic [WORD_WIDTH-1:0]  ip_i,
  output logic [WORD_WIDTH-1:0]  mem_addr_o,
  output logic                   mem_req_o,
  input  logic                   mem_ack_i,
  input  logic [INSTR_WIDTH-1:0] mem_data_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  input  logic                   branch_taken_i,
  input  logic [WORD_WIDTH-1:0]  branch_offset_i,
  output logic [WORD_WIDTH-1:0]  ip_adj_o,
  output logic                   ip_update_o,
  output logic                   busy_o,
  output logic                   fault_o
);

  // S_FAULT keeps its encoding in every build. Without the watchdog the
  // state is simply unreachable.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HOLD    = 3'd2,
    S_ADVANCE = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [WORD_WIDTH-1:0] SEQ_STEP = WORD_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   mem_req_q, mem_req_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [WORD_WIDTH-1:0]  ip_adj_q, ip_adj_d;
  logic                   ip_update_q, ip_update_d;
  logic                   busy_q, busy_d;
  logic                   fault_q, fault_d;

`ifdef FETCH_TIMEOUT_EN
  // The counter must be able to hold TIMEOUT_CYCLES-1, the last count seen
  // before the watchdog fires.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  // The watchdog limit only matters when the watchdog is built in.
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state logic and registered-output targets.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_req_d     = mem_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    ip_adj_d      = ip_adj_q;
    ip_update_d   = 1'b0;
    fault_d       = fault_q;
`ifdef FETCH_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          mem_addr_d = ip_i;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end
      end

      S_REQ: begin
        // A late ack still wins over the watchdog in the same cycle.
        if (mem_ack_i) begin
          instr_d       = mem_data_i;
          mem_req_d     = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = S_FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
      end

      S_HOLD: begin
        if (instr_valid_q && instr_ready_i) begin
          instr_valid_d = 1'b0;
          ip_adj_d      = branch_taken_i ? branch_offset_i : SEQ_STEP;
          ip_update_d   = 1'b1;
          state_d       = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        // The pointer updated on the rising edge of ip_update, so ip_i is
        // already the post-adjustment address here.
        if (run_i) begin
          mem_addr_d = ip_i;
          mem_req_d  = 1'b1;
          state_d    = S_REQ;
`ifdef FETCH_TIMEOUT_EN
          tmo_cnt_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
`ifdef FETCH_TIMEOUT_EN
        state_d = S_FAULT;
`else
        state_d = S_IDLE;
`endif
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. An asynchronous reset drops the request and
  // the valid flag immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      mem_addr_q    <= '0;
      mem_req_q     <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      ip_adj_q      <= '0;
      ip_update_q   <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      ip_adj_q      <= ip_adj_d;
      ip_update_q   <= ip_update_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog counter, cleared on every entry to S_REQ.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign mem_addr_o    = mem_addr_q;
  assign mem_req_o     = mem_req_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign ip_adj_o      = ip_adj_q;
  assign ip_update_o   = ip_update_q;
  assign busy_o        = busy_q;
`ifdef FETCH_TIMEOUT_EN
  assign fault_o       = fault_q;
`else
  assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// The memory agent records each word it returns, and the decoder agent records
// each IP adjustment it implies. A separate monitor pops both queues whenever
// the DUT presents an instruction or an update strobe. The bench also tracks
// the expected IP arithmetically and checks every new fetch address against it.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] ip;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic [15:0] ip_adj;
  logic        ip_update;
  logic        busy;
  logic        fault;

  always #5 clk = ~clk;

  instr_fetch #(.WORD_WIDTH(16), .INSTR_WIDTH(16), .TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run), .ip_i(ip),
    .mem_addr_o(mem_addr), .mem_req_o(mem_req), .mem_ack_i(mem_ack),
    .mem_data_i(mem_data), .instr_o(instr), .instr_valid_o(instr_valid),
    .instr_ready_i(instr_ready), .branch_taken_i(branch_taken),
    .branch_offset_i(branch_offset), .ip_adj_o(ip_adj),
    .ip_update_o(ip_update), .busy_o(busy), .fault_o(fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction pointer: adds ip_adj on the rising edge of the strobe.
  always @(posedge ip_update) ip <= ip + ip_adj;

  // Instruction memory contents, generated lazily.
  logic [15:0] mem [logic [15:0]];
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // Scoreboard queues and the expected-IP model.
  logic [15:0] instr_q[$];
  logic [15:0] adj_q[$];
  logic [15:0] exp_ip;

  // Agent knobs.
  int   ack_fix  = 0;
  int   rdy_fix  = 0;
  bit   mem_en   = 1'b1;
  bit   noise_en = 1'b0;
  int   br_mode  = 0;
  logic [15:0] dir_off = 16'h0000;

  // Memory responder: acks after a delay and records the word it returns.
  int ack_cnt = -1;
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0;
      ack_cnt = -1;
    end else if (mem_req) begin
      if (!mem_en) begin
        mem_ack = 1'b0;
      end else begin
        if (ack_cnt < 0) ack_cnt = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 3));
        if (ack_cnt == 0) begin
          mem_data = mem_rd(mem_addr);
          mem_ack  = 1'b1;
          instr_q.push_back(mem_data);
          ack_cnt  = -1;
        end else begin
          mem_ack  = 1'b0;
          mem_data = 16'($urandom);
          ack_cnt--;
        end
      end
    end else begin
      ack_cnt  = -1;
      mem_ack  = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_data = 16'($urandom);
    end
  end

  // Decoder: accepts after a delay, decides the branch and records the adjustment.
  int rdy_cnt = -1;
  always @(negedge clk) begin
    logic        tk;
    logic [15:0] off;
    logic [15:0] adj;
    if (reset) begin
      instr_ready = 1'b0;
      rdy_cnt     = -1;
    end else if (instr_valid) begin
      if (rdy_cnt < 0) rdy_cnt = (rdy_fix >= 0) ? rdy_fix : int'($urandom_range(0, 3));
      if (rdy_cnt == 0) begin
        if (br_mode == 0) begin
          tk = 1'b0; off = 16'($urandom);
        end else if (br_mode == 1) begin
          tk = 1'b1; off = dir_off;
        end else begin
          tk  = ($urandom_range(0, 2) == 0);
          off = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
        end
        branch_taken  = tk;
        branch_offset = off;
        instr_ready   = 1'b1;
        adj = tk ? off : 16'd1;
        adj_q.push_back(adj);
        exp_ip  = exp_ip + adj;
        rdy_cnt = -1;
      end else begin
        instr_ready   = 1'b0;
        branch_taken  = 1'($urandom_range(0, 1));
        branch_offset = 16'($urandom);
        rdy_cnt--;
      end
    end else begin
      rdy_cnt       = -1;
      instr_ready   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      branch_taken  = 1'($urandom_range(0, 1));
      branch_offset = 16'($urandom);
    end
  end

  // Monitor: compares DUT outputs against the scoreboard whenever they are presented.
  logic        prev_req, prev_valid, prev_upd;
  logic [15:0] held_addr, held_instr, last_adj, want;
  int          upd_count = 0;
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0; prev_valid = 1'b0; prev_upd = 1'b0; last_adj = 16'h0;
    end else begin
      if (mem_req && !prev_req) begin
        check_eq("fetch_addr", mem_addr, exp_ip);
        held_addr = mem_addr;
      end else if (mem_req) begin
        check_eq("addr_stable", mem_addr, held_addr);
      end
      if (instr_valid && !prev_valid) begin
        if (instr_q.size() == 0) begin
          check_eq("instr_unexpected", 32'd1, 32'd0);
        end else begin
          want = instr_q.pop_front();
          check_eq("instr_data", instr, want);
        end
        held_instr = instr;
      end else if (instr_valid) begin
        check_eq("instr_stable", instr, held_instr);
      end
      if (ip_update) begin
        upd_count++;
        check_eq("upd_one_cycle", prev_upd, 1'b0);
        if (adj_q.size() == 0) begin
          check_eq("adj_unexpected", 32'd1, 32'd0);
        end else begin
          want = adj_q.pop_front();
          check_eq("ip_adj", ip_adj, want);
        end
        last_adj = ip_adj;
      end else begin
        check_eq("ip_adj_hold", ip_adj, last_adj);
      end
      prev_req   = mem_req;
      prev_valid = instr_valid;
      prev_upd   = ip_update;
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    check_eq(name, busy, 1'b0);
  endtask

  task automatic wait_sig_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 100) begin @(negedge clk); n++; end
    check_eq(name, instr_valid, 1'b1);
  endtask

  task automatic wait_sig_upd(input string name);
    int n = 0;
    while (!ip_update && n < 100) begin @(negedge clk); n++; end
    check_eq(name, ip_update, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n, rl, vl, u0;
    reset = 1'b1; run = 1'b0; ip = 16'h0010; exp_ip = 16'h0010;
    mem_ack = 1'b0; mem_data = 16'h0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_offset = 16'h0;
    mem[16'h0010] = 16'hA5A5;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 16'h0);
    check_eq("rst_instr", instr, 16'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_adj", ip_adj, 16'h0);
    check_eq("rst_upd", ip_update, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait fetch from 0x0010.
    ack_fix = 0; rdy_fix = 0; br_mode = 0;
    run = 1'b1;
    @(negedge clk);
    check_eq("t1_req", mem_req, 1'b1);
    check_eq("t1_addr", mem_addr, 16'h0010);
    check_eq("t1_busy", busy, 1'b1);
    @(negedge clk);
    check_eq("t1_valid", instr_valid, 1'b1);
    check_eq("t1_instr", instr, 16'hA5A5);
    run = 1'b0;
    @(negedge clk);
    check_eq("t1_upd", ip_update, 1'b1);
    check_eq("t1_adj", ip_adj, 16'h0001);
    check_eq("t1_valid_drop", instr_valid, 1'b0);
    @(negedge clk);
    check_eq("t1_upd_end", ip_update, 1'b0);
    check_eq("t1_idle", busy, 1'b0);
    check_eq("t1_ip", ip, 16'h0011);

    // Slow memory and slow decoder.
    ack_fix = 4; rdy_fix = 3;
    u0 = upd_count;
    run = 1'b1;
    rl = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (mem_req) rl++;
    end while (!(rl > 0 && !mem_req) && n < 50);
    check_eq("t2_req_len", rl, 5);
    run = 1'b0;
    vl = instr_valid ? 1 : 0; n = 0;
    while (instr_valid && n < 50) begin
      @(negedge clk); n++;
      if (instr_valid) vl++;
    end
    check_eq("t2_valid_len", vl, 4);
    wait_idle("t2_idle");
    check_eq("t2_upd_count", upd_count - u0, 1);

    // Backward branch, then refetch from the updated IP.
    ack_fix = 0; rdy_fix = 0; br_mode = 1; dir_off = 16'hFFFC;
    run = 1'b1;
    wait_sig_upd("t3_upd_seen");
    check_eq("t3_adj", ip_adj, 16'hFFFC);
    br_mode = 0;
    @(negedge clk);
    check_eq("t3_req", mem_req, 1'b1);
    check_eq("t3_addr", mem_addr, 16'h000E);
    run = 1'b0;
    wait_idle("t3_idle");

    // run dropped while holding an instruction.
    ack_fix = 1; rdy_fix = 2;
    run = 1'b1;
    wait_sig_valid("t4_valid_seen");
    run = 1'b0;
    u0 = upd_count;
    wait_idle("t4_idle");
    check_eq("t4_upd_count", upd_count - u0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_no_req", mem_req, 1'b0);
    end
    check_eq("t4_ip", ip, exp_ip);

    // Asynchronous reset in the middle of a request.
    mem_en = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5_req_before", mem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_req_async", mem_req, 1'b0);
    check_eq("t5_valid_async", instr_valid, 1'b0);
    check_eq("t5_busy_async", busy, 1'b0);
    @(negedge clk);
    run = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t5_idle_after", busy, 1'b0);
    check_eq("t5_no_req_after", mem_req, 1'b0);

    // Randomized traffic with noise on ack and ready outside their windows.
    ack_fix = -1; rdy_fix = -1; br_mode = 2; noise_en = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) run = ~run;
    end
    run = 1'b0;
    wait_idle("rand_idle");
    noise_en = 1'b0;
    @(negedge clk);
    check_eq("rand_instr_q_empty", instr_q.size(), 0);
    check_eq("rand_adj_q_empty", adj_q.size(), 0);
    check_eq("rand_ip", ip, exp_ip);

`ifdef FETCH_TIMEOUT_EN
    mem_en = 1'b0;
    run = 1'b1;
    rl = 0; n = 0;
    do begin
      @(negedge clk); n++;
      if (mem_req) rl++;
    end while (!fault && n < 100);
    check_eq("tmo_req_cycles", rl, 15);
    check_eq("tmo_fault", fault, 1'b1);
    check_eq("tmo_req_drop", mem_req, 1'b0);
    check_eq("tmo_busy", busy, 1'b1);
    run = 1'b0; mem_en = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("tmo_sticky", fault, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("tmo_cleared", fault, 1'b0);
    reset = 1'b0;
    @(negedge clk);
`else
    check_eq("fault_tied_low", fault, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
